// File: rtl/pipe_game_defs.sv
// Shared definitions for the pipe game: spawn FSM state encoding, screen geometry,
// score and gap-Y widths, and the gap RNG seed.
package pipe_game_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SPAWN  = 2'd2,
    FLIGHT = 2'd3
  } spawn_state_t;

  localparam int SCREEN_H = 480;
  localparam int Y_MID    = 240;
  localparam int SCORE_W  = 10;
  localparam int Y_W      = 10;
  localparam int LFSR_W   = 9;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 9'h1FF;

endpackage

// File: rtl/pipe_gap_rng.sv
// Free-running 9-bit Fibonacci LFSR (taps 9,5) folded into a gap-centre Y candidate
// in [MIN_Y, MIN_Y+SPAN]. SPAN must lie in 255..510 so the single fold covers 0..511.
module pipe_gap_rng
  import pipe_game_defs::*;
#(
  parameter int MIN_Y = 100,
  parameter int SPAN  = 280
) (
  input  logic           animationCLOCK,
  input  logic           animationRESETn,
  output logic [Y_W-1:0] gapY
);

  logic [LFSR_W-1:0] lfsr;
  logic [Y_W-1:0]    r;
  logic [Y_W-1:0]    v;

  // x^9 + x^5 + 1 is primitive: from a non-zero seed the register never reaches zero.
  always_ff @(posedge animationCLOCK or negedge animationRESETn) begin
    if (!animationRESETn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[8] ^ lfsr[4]};
    end
  end

  always_comb begin
    r = {1'b0, lfsr};
    if (r <= Y_W'(SPAN)) begin
      v = r;
    end else begin
      v = r - Y_W'(SPAN + 1);
    end
    gapY = Y_W'(MIN_Y) + v;
  end

endmodule

// File: rtl/pipe_spawn_ctrl.sv
// Spawn-side pacing of the pipe animator: one pipe in flight at a time, score counting.
// Optional flight watchdog is compiled in with `define PIPE_SPAWN_WDOG_EN.
module pipe_spawn_ctrl
  import pipe_game_defs::*;
#(
  parameter int MIN_Y         = 100,
  parameter int SPAN          = 280,
  parameter int INTERVAL_BASE = 120,
  parameter int INTERVAL_STEP = 10,
  parameter int INTERVAL_MIN  = 40,
  parameter int SCORE_MAX     = 999,
  parameter int TIMEOUT_TICKS = 1023
) (
  input  logic               animationCLOCK,
  input  logic               animationRESETn,
  input  logic               gameStart,
  input  logic               gameOver,
  input  logic               endOfMapPipe,
  output logic               spawnPipe,
  output logic [Y_W-1:0]     pointY,
  output logic [SCORE_W-1:0] score,
  output logic               running,
  output logic               timeoutErr,
  output spawn_state_t       dbgState
);

  localparam int CNT_W = 10;

  // Pulse protocol with the animator: spawnPipe and endOfMapPipe are single-cycle strobes
  // with no back-pressure; endOfMapPipe is only acted on while a pipe is in FLIGHT.

  spawn_state_t         state;
  logic [CNT_W-1:0]     cnt;
  logic                 spawnQ;
  logic [Y_W-1:0]       gapY;
  logic [SCORE_W-1:0]   scoreInc;

  function automatic logic [CNT_W-1:0] spawn_interval(input logic [SCORE_W-1:0] s);
    logic [15:0] dec;
    dec = 16'(s / SCORE_W'(10)) * 16'(INTERVAL_STEP);
    // Clamp decided before subtracting so high scores never wrap the counter.
    if (dec >= 16'(INTERVAL_BASE - INTERVAL_MIN)) begin
      return CNT_W'(INTERVAL_MIN);
    end
    return CNT_W'(INTERVAL_BASE) - CNT_W'(dec);
  endfunction

  pipe_gap_rng #(
    .MIN_Y (MIN_Y),
    .SPAN  (SPAN)
  ) u_gap_rng (
    .animationCLOCK  (animationCLOCK),
    .animationRESETn (animationRESETn),
    .gapY            (gapY)
  );

  assign scoreInc = (score < SCORE_W'(SCORE_MAX)) ? score + SCORE_W'(1) : score;

`ifdef PIPE_SPAWN_WDOG_EN
  localparam int FCNT_W = $clog2(TIMEOUT_TICKS + 1);
  logic [FCNT_W-1:0] flightCnt;
  logic              timeoutQ;
  assign timeoutErr = timeoutQ;
`else
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge animationCLOCK or negedge animationRESETn) begin
    if (!animationRESETn) begin
      state  <= IDLE;
      cnt    <= '0;
      spawnQ <= 1'b0;
      pointY <= Y_W'(Y_MID);
      score  <= '0;
`ifdef PIPE_SPAWN_WDOG_EN
      flightCnt <= '0;
      timeoutQ  <= 1'b0;
`endif
    end else begin
      spawnQ <= 1'b0;
      if (gameOver) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (gameStart) begin
              cnt   <= CNT_W'(INTERVAL_BASE);
              score <= '0;
`ifdef PIPE_SPAWN_WDOG_EN
              timeoutQ <= 1'b0;
`endif
              state <= WAIT;
            end
          end
          WAIT: begin
            // Strobe and Y are registered together so both are valid in the SPAWN cycle.
            if (cnt <= CNT_W'(1)) begin
              state  <= SPAWN;
              spawnQ <= 1'b1;
              pointY <= gapY;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          SPAWN: begin
            state <= FLIGHT;
`ifdef PIPE_SPAWN_WDOG_EN
            flightCnt <= '0;
`endif
          end
          FLIGHT: begin
            if (endOfMapPipe) begin
              score <= scoreInc;
              cnt   <= spawn_interval(scoreInc);
              state <= WAIT;
            end
`ifdef PIPE_SPAWN_WDOG_EN
            else if (flightCnt == FCNT_W'(TIMEOUT_TICKS - 1)) begin
              timeoutQ <= 1'b1;
              cnt      <= spawn_interval(score);
              state    <= WAIT;
            end else begin
              flightCnt <= flightCnt + FCNT_W'(1);
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // An abort arriving in the SPAWN cycle itself still suppresses the strobe.
  assign spawnPipe = spawnQ & ~gameOver;
  assign running   = (state != IDLE);
  assign dbgState  = state;

endmodule

// File: tb/tb_pipe_spawn_ctrl.sv
// Randomized bench for pipe_spawn_ctrl against an event-time reference model
// (spawn due-times, saturating score, folded LFSR value).
`timescale 1ns/1ps
module tb_pipe_spawn_ctrl;
  import pipe_game_defs::*;

  localparam int MIN_Y   = 100;
  localparam int SPAN    = 280;
  localparam int I_BASE  = 120;
  localparam int I_STEP  = 10;
  localparam int I_MIN   = 40;
  localparam int S_MAX   = 999;
  localparam int T_TICKS = 1023;

  // ---------------- clock / reset / DUT ----------------
  logic         animationCLOCK  = 1'b0;
  logic         animationRESETn = 1'b0;
  logic         gameStart       = 1'b0;
  logic         gameOver        = 1'b0;
  logic         endOfMapPipe    = 1'b0;
  logic         spawnPipe;
  logic [9:0]   pointY;
  logic [9:0]   score;
  logic         running;
  logic         timeoutErr;
  spawn_state_t dbgState;

  always #5 animationCLOCK = ~animationCLOCK;

  pipe_spawn_ctrl dut (
    .animationCLOCK  (animationCLOCK),
    .animationRESETn (animationRESETn),
    .gameStart       (gameStart),
    .gameOver        (gameOver),
    .endOfMapPipe    (endOfMapPipe),
    .spawnPipe       (spawnPipe),
    .pointY          (pointY),
    .score           (score),
    .running         (running),
    .timeoutErr      (timeoutErr),
    .dbgState        (dbgState)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 waiting for a due spawn time, 2 spawning, 3 pipe flying
  int m_mode, m_due, m_fly0, m_score, m_py, m_terr, m_lfsr, m_k;

  function automatic int lfsr_next(input int r);
    return ((r << 1) & 'h1FF) | (((r >> 8) ^ (r >> 4)) & 1);
  endfunction

  function automatic int lfsr_adv(input int r, input int n);
    int x;
    x = r;
    for (int i = 0; i < n; i++) x = lfsr_next(x);
    return x;
  endfunction

  function automatic int gap_y(input int r);
    return MIN_Y + ((r <= SPAN) ? r : r - SPAN - 1);
  endfunction

  function automatic int gap_ticks(input int s);
    int v;
    v = I_BASE - (s / 10) * I_STEP;
    return (v < I_MIN) ? I_MIN : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_due = 0; m_fly0 = 0; m_score = 0;
    m_py = 240; m_terr = 0; m_lfsr = 'h1FF; m_k = 0;
    exp_q.delete();
  endtask

  task automatic model_update(input bit gs, input bit go, input bit eom);
    if (go) begin
      if (m_mode == 2 && exp_q.size() > 0) void'(exp_q.pop_back());
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (gs) begin
             m_score = 0; m_terr = 0;
             m_due = m_k + gap_ticks(0) + 1;
             m_mode = 1;
           end
        1: if (m_k + 1 == m_due) begin
             m_py = gap_y(m_lfsr);
             exp_q.push_back(10'(m_py));
             m_mode = 2;
           end
        2: begin
             m_fly0 = m_k + 1;
             m_mode = 3;
           end
        default: begin
          if (eom) begin
            if (m_score < S_MAX) m_score++;
            m_due = m_k + gap_ticks(m_score) + 1;
            m_mode = 1;
          end
`ifdef PIPE_SPAWN_WDOG_EN
          else if (m_k - m_fly0 + 1 == T_TICKS) begin
            m_terr = 1;
            m_due = m_k + gap_ticks(m_score) + 1;
            m_mode = 1;
          end
`endif
        end
      endcase
    end
    m_lfsr = lfsr_next(m_lfsr);
    m_k++;
  endtask

  // ---------------- driver tasks ----------------
  bit sp_seen;
  int cur_k, spawn_k, eom_k;

  // Called at posedge+1: drive, sample on negedge, advance model, return at next posedge+1.
  task automatic step(input bit gs, input bit go, input bit eom);
    gameStart = gs; gameOver = go; endOfMapPipe = eom;
    @(negedge animationCLOCK);
    cur_k = m_k;
    check("running", running, 32'(m_mode != 0));
    check("spawnPipe", spawnPipe, 32'((m_mode == 2) && !go));
    check("score", score, m_score);
    check("pointY", pointY, m_py);
    check("timeoutErr", timeoutErr, m_terr);
    sp_seen = (spawnPipe === 1'b1);
    if (sp_seen) begin
      if (exp_q.size() == 0) check("spawn_unexpected", 1, 0);
      else check("spawn_pointY", pointY, exp_q.pop_front());
    end
    model_update(gs, go, eom);
    @(posedge animationCLOCK); #1;
  endtask

  task automatic run_to_spawn(input int budget, input bit noise);
    int n;
    bit gs, eom;
    n = 0;
    sp_seen = 1'b0;
    while (!sp_seen && n < budget) begin
      gs  = noise && ($urandom_range(0, 15) == 0);
      eom = noise && ($urandom_range(0, 7) == 0);
      step(gs, 1'b0, eom);
      n++;
    end
    if (!sp_seen) check("spawn_wait_expired", 0, 1);
    spawn_k = cur_k;
  endtask

  task automatic fly(input int delay);
    for (int d = 0; d < delay; d++) step(1'b0, 1'b0, 1'b0);
    eom_k = m_k;
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic start_aligned(input int target);
    int n;
    n = 0;
    while (lfsr_adv(m_lfsr, I_BASE) != target && n < 600) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    step(1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  bit at89;
  int guard;

  initial begin
    gameStart = 1'b1;
    repeat (3) @(posedge animationCLOCK);
    #1;
    check("rst_spawnPipe", spawnPipe, 0);
    check("rst_pointY", pointY, 240);
    check("rst_score", score, 0);
    check("rst_running", running, 0);
    check("rst_timeoutErr", timeoutErr, 0);
    check("rst_state", dbgState, IDLE);
    animationRESETn = 1'b1;
    model_reset();

    // First game: start accepted in cycle 0, first strobe 121 ticks later.
    step(1'b1, 1'b0, 1'b0);
    run_to_spawn(200, 1'b0);
    check("first_spawn_tick", spawn_k, 121);
    check("first_score", score, 0);
    step(1'b0, 1'b0, 1'b0);
    check("pulse_width", spawnPipe, 0);

    // Fifteen pipes with random flight times and ignored noise in WAIT/SPAWN.
    for (int i = 0; i < 15; i++) begin
      fly($urandom_range(0, 20));
      run_to_spawn(200, 1'b1);
    end
    check("score_15", score, 15);
    check("gap_after_15", spawn_k - eom_k, 111);

    // Abort exactly in the spawn cycle.
    fly($urandom_range(0, 5));
    guard = 0;
    while (m_mode != 2 && guard < 200) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 1'b1, 1'b0);
    check("abort_no_strobe", sp_seen, 0);
    step(1'b0, 1'b0, 1'b0);
    check("abort_state", dbgState, IDLE);
    check("abort_score_held", score, 16);

    // Idle noise: endOfMapPipe and gameOver do nothing to the score.
    for (int i = 0; i < 30; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("idle_score_held", score, 16);
    step(1'b1, 1'b1, 1'b0);
    check("start_and_over_idle", dbgState, IDLE);

    // Known LFSR values at the spawn decision.
    start_aligned('h1FF);
    run_to_spawn(200, 1'b0);
    check("pointY_lfsr_1ff", pointY, 330);
    step(1'b0, 1'b1, 1'b0);
    start_aligned(200);
    run_to_spawn(200, 1'b0);
    check("pointY_lfsr_200", pointY, 300);

    // Flight with no end-of-map pulse.
    repeat (T_TICKS) step(1'b0, 1'b0, 1'b0);
`ifdef PIPE_SPAWN_WDOG_EN
    check("wdog_flag", timeoutErr, 1);
    check("wdog_state", dbgState, WAIT);
    check("wdog_score", score, 0);
`else
    check("no_wdog_flag", timeoutErr, 0);
    check("no_wdog_state", dbgState, FLIGHT);
    repeat (50) step(1'b0, 1'b0, 1'b0);
    check("no_wdog_still_flying", dbgState, FLIGHT);
    step(1'b0, 1'b0, 1'b1);
`endif
    run_to_spawn(200, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in mid-flight.
    animationRESETn = 1'b0;
    #1;
    check("arst_spawnPipe", spawnPipe, 0);
    check("arst_pointY", pointY, 240);
    check("arst_score", score, 0);
    check("arst_running", running, 0);
    check("arst_timeoutErr", timeoutErr, 0);
    @(posedge animationCLOCK);
    @(posedge animationCLOCK); #1;
    animationRESETn = 1'b1;
    model_reset();

    // Long game up to score saturation; interval clamp checked at score 90.
    step(1'b1, 1'b0, 1'b0);
    run_to_spawn(200, 1'b0);
    guard = 0;
    while (m_score < 998 && guard < 1100) begin
      at89 = (m_score == 89);
      fly($urandom_range(0, 3));
      run_to_spawn(200, 1'b0);
      if (at89) check("clamp_at_90", spawn_k - eom_k, 41);
      guard++;
    end
    fly(0);
    check("score_sat_999", score, 999);
    run_to_spawn(200, 1'b0);
    check("gap_at_999", spawn_k - eom_k, 41);
    fly(0);
    check("score_stays_999", score, 999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got %0d cycles expected completion", m_k);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "bench time limit");
  end

endmodule
